// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   localparam int APB_AW = 32;
   localparam int APB_DW = 32;

endpackage

// File: rtl/apb_wdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the last permitted one.
module apb_wdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   logic [CW-1:0] count;

   // Saturating so a stalled counter can never wrap back into range.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {CW{1'b1}})) begin
         count <= count + CW'(1);
      end
   end

   assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: one valid/ready command in, one APB transfer, one response out.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int AW      = APB_AW,
   parameter int DW      = APB_DW,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_write,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_timeout,
   output logic          psel,
   output logic          penable,
   output logic          pwrite,
   output logic [AW-1:0] paddr,
   output logic [DW-1:0] pwdata,
   input  logic [DW-1:0] prdata,
   input  logic          pready
);

   apb_state_e state;
   logic       wd_expire;

   assign cmd_ready = (state == IDLE);

   // Count restarts while in SETUP so ACCESS always begins at zero.
   apb_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk   (clk),
      .rst   (rst),
      .clear (state == SETUP),
      .enable((state == ACCESS) && !pready),
      .expire(wd_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  pwrite  <= cmd_write;
                  paddr   <= cmd_addr;
                  pwdata  <= cmd_wdata;
                  psel    <= 1'b1;
                  penable <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // A ready slave on the limit cycle still completes normally.
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else if (wd_expire) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl with a configurable APB slave and protocol monitor.
module tb_apb_master_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0;

   apb_master_ctrl #(
      .AW(32),
      .DW(32),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      logic        tmo;
      int          lat;
      int          alen;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int hs_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: wait slv_wait ACCESS cycles (negative = never ready); early mode also raises pready in SETUP.
   int          slv_wait = 0;
   int          slv_idx = -1;
   logic        slv_early = 1'b0;
   logic [31:0] slv_rdata = '0;

   always @(posedge clk) begin
      #1;
      if (psel && penable) slv_idx = slv_idx + 1;
      else slv_idx = -1;
      pready = psel && ((penable && (slv_idx == slv_wait)) || (slv_early && !penable));
      prdata = pready ? slv_rdata : ~slv_rdata;
   end

   // Monitor: protocol rules, timing and scoreboard pop on response handshake.
   logic        m_psel = 1'b0, m_pen = 1'b0, m_rv = 1'b0;
   int          m_acc = 0, m_alen = 0;
   logic [31:0] s_addr, s_wdata;
   logic        s_write;
   logic [32:0] s_rsp;

   always @(negedge clk) begin
      if (rst) begin
         m_psel = 1'b0;
         m_pen  = 1'b0;
         m_rv   = 1'b0;
      end else begin
         chk("pen_without_psel", 64'(penable & ~psel), 64'(0));
         if (psel && !m_psel) begin
            m_acc   = cyc;
            m_alen  = 0;
            s_addr  = paddr;
            s_wdata = pwdata;
            s_write = pwrite;
            chk("setup_phase", 64'(penable), 64'(0));
         end
         if (psel && m_psel)
            chk("apb_stable", {31'(0), pwrite, paddr ^ pwdata}, {31'(0), s_write, s_addr ^ s_wdata});
         if (penable && !m_pen)
            chk("access_after_setup", 64'(m_psel & ~m_pen), 64'(1));
         if (psel && penable) m_alen++;
         if (rsp_valid && !m_rv) begin
            s_rsp = {rsp_timeout, rsp_rdata};
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(1), 64'(0));
            end else begin
               chk("latency", 64'(cyc - m_acc), 64'(exp_q[0].lat));
               chk("access_len", 64'(m_alen), 64'(exp_q[0].alen));
               chk("paddr", 64'(s_addr), 64'(exp_q[0].a));
               chk("pwrite_pwdata", {31'(0), s_write, s_wdata}, {31'(0), exp_q[0].w, exp_q[0].d});
               chk("apb_idle_after", 64'({psel, penable}), 64'(0));
            end
         end
         if (rsp_valid && m_rv)
            chk("rsp_hold", 64'({rsp_timeout, rsp_rdata}), 64'(s_rsp));
         if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
            hs_cyc = cyc + 1;
         end
         m_psel = psel;
         m_pen  = penable;
         m_rv   = rsp_valid;
      end
   end

   task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int wn, input logic [31:0] rd);
      exp_t e;
      slv_wait  = wn;
      slv_rdata = rd;
      e.w    = w;
      e.a    = a;
      e.d    = d;
      e.tmo  = (wn < 0) || (wn >= TIMEOUT);
      e.rd   = (w || e.tmo) ? 32'h0 : rd;
      e.lat  = e.tmo ? TIMEOUT + 1 : wn + 2;
      e.alen = e.tmo ? TIMEOUT : wn + 1;
      exp_q.push_back(e);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   task automatic take();
      int n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
      end
      if (n >= 50) chk("accept_bound", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("rsp_bound", 64'(0), 64'(1));
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int wn, input logic [31:0] rd);
      present(w, a, d, wn, rd);
      take();
      wait_rsp();
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 64'({psel, penable, pwrite, rsp_valid, rsp_timeout}), 64'(0));
      chk("reset_regs", {paddr, pwdata | rsp_rdata}, 64'(0));
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Zero-wait write; slave already ready in SETUP, which must be ignored.
      slv_early = 1'b1;
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h5555AAAA);
      slv_early = 1'b0;

      xfer(1'b0, 32'h20, 32'h0, 3, 32'h12345678);
      xfer(1'b0, 32'h30, 32'h0, -1, 32'hFFFF0000);
      xfer(1'b0, 32'h34, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5);
      xfer(1'b1, 32'h38, 32'h00000001, TIMEOUT, 32'h11111111);

      // Backpressure with the next command already waiting.
      rsp_ready = 1'b0;
      present(1'b0, 32'h50, 32'h0, 1, 32'h0BADF00D);
      take();
      for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      @(posedge clk);
      #1;
      present(1'b1, 32'h54, 32'h00000077, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      take();
      chk("b2b_accept", 64'(acc_cyc - hs_cyc), 64'(1));
      wait_rsp();

      for (int i = 0; i < 6; i++)
         xfer(1'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom,
              int'($urandom_range(0, 4)), $urandom);

      // Asynchronous reset while the slave is stalling.
      present(1'b0, 32'h60, 32'h0, -1, 32'h0);
      take();
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_apb_drop", 64'({psel, penable}), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_paddr", 64'(paddr), 64'(0));
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_no_rsp", 64'(rsp_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      xfer(1'b0, 32'h64, 32'h0, 2, 32'hCAFEF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
